// File: rtl/pm_fetch_sequencer.sv
// picoMips program counter and fetch sequencer: resolves HEI halts locally,
// qualifies the instruction stream for the datapath and debounces SW8.
module pm_fetch_sequencer #(
    parameter logic [5:0] OP_HEI          = 6'b000001,
    parameter int         LAST_ADDR       = 27,
    parameter int         DEBOUNCE_CYCLES = 4
) (
    input  logic       Clock,
    input  logic       nReset,
    input  logic       SW8,
    input  logic [9:0] Instruction,
    output logic [4:0] Addr,
    output logic       Instr_valid,
    output logic [4:0] Instr_addr,
    output logic       Waiting,
    output logic       Sw8_db
);

    localparam logic [4:0] LAST = 5'(LAST_ADDR);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {ST_PRIME, ST_RUN, ST_WAIT} state_t;

    state_t        state, state_next;
    logic [4:0]    addr_next, instr_addr_next;
    logic          waiting_next;
    logic          wait_level, wait_level_next;
    logic          sync_meta, sync_out;
    logic [CW-1:0] db_count;
    logic          is_hei;
    logic          unused_imm;

    function automatic logic [4:0] next_addr(input logic [4:0] a);
        return (a == LAST) ? 5'd0 : a + 5'd1;
    endfunction

    assign is_hei     = (Instruction[9:4] == OP_HEI);
    // Only imm[0] matters to HEI; the other immediate bits belong to the datapath.
    assign unused_imm = ^Instruction[3:1];

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            sync_meta <= 1'b0;
            sync_out  <= 1'b0;
            db_count  <= '0;
            Sw8_db    <= 1'b0;
        end else begin
            sync_meta <= SW8;
            sync_out  <= sync_meta;
            if (sync_out != Sw8_db) begin
                if (db_count == CNT_LAST) begin
                    Sw8_db   <= ~Sw8_db;
                    db_count <= '0;
                end else begin
                    db_count <= db_count + CW'(1);
                end
            end else begin
                db_count <= '0;
            end
        end
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state      <= ST_PRIME;
            Addr       <= 5'd0;
            Instr_addr <= 5'd0;
            Waiting    <= 1'b0;
            wait_level <= 1'b0;
        end else begin
            state      <= state_next;
            Addr       <= addr_next;
            Instr_addr <= instr_addr_next;
            Waiting    <= waiting_next;
            wait_level <= wait_level_next;
        end
    end

    // In WAIT, Addr already points past the HEI, so resuming just advances it.
    always_comb begin
        state_next      = state;
        addr_next       = Addr;
        instr_addr_next = Instr_addr;
        waiting_next    = Waiting;
        wait_level_next = wait_level;
        case (state)
            ST_PRIME: begin
                addr_next       = next_addr(5'd0);
                instr_addr_next = 5'd0;
                state_next      = ST_RUN;
            end
            ST_RUN: begin
                if (is_hei && (Sw8_db == Instruction[0])) begin
                    wait_level_next = Instruction[0];
                    waiting_next    = 1'b1;
                    state_next      = ST_WAIT;
                end else begin
                    instr_addr_next = Addr;
                    addr_next       = next_addr(Addr);
                end
            end
            ST_WAIT: begin
                if (Sw8_db != wait_level) begin
                    instr_addr_next = Addr;
                    addr_next       = next_addr(Addr);
                    waiting_next    = 1'b0;
                    state_next      = ST_RUN;
                end
            end
            default: state_next = ST_PRIME;
        endcase
    end

    always_comb begin
        Instr_valid = (state == ST_RUN) && !is_hei;
    end

endmodule
